// File: rtl/pmem_line_responder.sv
// pmem_line_responder
// Memory end of the pmem_read/pmem_write/pmem_resp cache-line handshake.
// It latches one request, waits LATENCY cycles, then returns or commits a
// full line and pulses pmem_resp for one cycle.
//
// Ports:
//   clk, rst_n      rising-edge clock, asynchronous active-low reset
//   pmem_read       line read request, held until pmem_resp
//   pmem_write      line write request, held until pmem_resp
//   pmem_address    line address (low OFS bits ignored, bits above OFS+IDX alias)
//   pmem_wdata      write line
//   pmem_rdata      read line, valid while pmem_resp=1 after a read (registered)
//   pmem_resp       one-cycle completion pulse (registered)
//   proto_err       sticky flag: read and write requested together
//   rd_count, wr_count, abort_count
//                   32-bit statistics counters, present only when the
//                   PMEM_RESP_STATS_EN macro is defined
//
// Array contents are not reset.
module pmem_line_responder #(
  parameter int LINE_BITS   = 256,
  parameter int ADDR_BITS   = 32,
  parameter int DEPTH_LINES = 64,
  parameter int LATENCY     = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 pmem_read,
  input  logic                 pmem_write,
  input  logic [ADDR_BITS-1:0] pmem_address,
  input  logic [LINE_BITS-1:0] pmem_wdata,
  output logic [LINE_BITS-1:0] pmem_rdata,
  output logic                 pmem_resp,
`ifdef PMEM_RESP_STATS_EN
  output logic [31:0]          rd_count,
  output logic [31:0]          wr_count,
  output logic [31:0]          abort_count,
`endif
  output logic                 proto_err
);

  localparam int OFS = $clog2(LINE_BITS / 8);
  localparam int IDX = $clog2(DEPTH_LINES);
  localparam logic [7:0] LAT_M1 = 8'(LATENCY - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [7:0]           cnt_q, cnt_d;
  logic                 op_write_q, op_write_d;
  logic [IDX-1:0]       idx_q, idx_d;
  logic [LINE_BITS-1:0] wdata_q, wdata_d;
  logic [LINE_BITS-1:0] rdata_q;
  logic                 resp_q;
  logic                 proto_err_q;
  logic [LINE_BITS-1:0] mem_q [DEPTH_LINES];

  logic                 enter_resp_s;
  logic                 abort_s;
  logic                 conflict_s;
  logic                 req_held_s;
  logic                 unused_addr_s;

  // Offset bits and aliased upper bits play no part in line selection.
  assign unused_addr_s = ^{pmem_address[ADDR_BITS-1:OFS+IDX], pmem_address[OFS-1:0]};

  // Next-state logic; the *_d values describe the transaction being entered
  // into RESP so the commit path is the same whether it came from IDLE or WAIT.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    op_write_d   = op_write_q;
    idx_d        = idx_q;
    wdata_d      = wdata_q;
    enter_resp_s = 1'b0;
    abort_s      = 1'b0;
    conflict_s   = 1'b0;
    // A conflicting request was latched as a read, so its read line governs.
    req_held_s   = op_write_q ? pmem_write : pmem_read;
    case (state_q)
      ST_IDLE: begin
        if (pmem_read || pmem_write) begin
          op_write_d = pmem_write & ~pmem_read;
          conflict_s = pmem_write & pmem_read;
          idx_d      = pmem_address[OFS+IDX-1:OFS];
          wdata_d    = pmem_wdata;
          cnt_d      = LAT_M1;
          if (LAT_M1 != 8'd0) begin
            state_d = ST_WAIT;
          end else begin
            state_d      = ST_RESP;
            enter_resp_s = 1'b1;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (!req_held_s) begin
          state_d = ST_IDLE;
          abort_s = 1'b1;
        end else if (cnt_q == 8'd1) begin
          state_d      = ST_RESP;
          enter_resp_s = 1'b1;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Control state, latched request and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 8'd0;
      op_write_q  <= 1'b0;
      idx_q       <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      resp_q      <= 1'b0;
      proto_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      op_write_q  <= op_write_d;
      idx_q       <= idx_d;
      wdata_q     <= wdata_d;
      resp_q      <= enter_resp_s;
      proto_err_q <= proto_err_q | conflict_s;
      if (enter_resp_s && !op_write_d) begin
        rdata_q <= mem_q[idx_d];
      end
    end
  end

  // Line array, not reset; the rst_n gate stops a commit while reset is held.
  always_ff @(posedge clk) begin
    if (rst_n && enter_resp_s && op_write_d) begin
      mem_q[idx_d] <= wdata_d;
    end
  end

  assign pmem_rdata = rdata_q;
  assign pmem_resp  = resp_q;
  assign proto_err  = proto_err_q;

`ifdef PMEM_RESP_STATS_EN
  logic [31:0] rd_count_q, wr_count_q, abort_count_q;

  // Statistics counters; they wrap naturally at 2^32.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_count_q    <= 32'd0;
      wr_count_q    <= 32'd0;
      abort_count_q <= 32'd0;
    end else begin
      if (enter_resp_s && !op_write_d) begin
        rd_count_q <= rd_count_q + 32'd1;
      end
      if (enter_resp_s && op_write_d) begin
        wr_count_q <= wr_count_q + 32'd1;
      end
      if (abort_s) begin
        abort_count_q <= abort_count_q + 32'd1;
      end
    end
  end

  assign rd_count    = rd_count_q;
  assign wr_count    = wr_count_q;
  assign abort_count = abort_count_q;
`endif

endmodule
